// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: FSM state encoding and ALU command encodings.
// Optional perf counters in alu_sched are enabled with ALU_SCHED_PERF_EN.
package alu_sched_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_sched_state_e;

  // Encodings understood by the execute-stage ALU; the scheduler never decodes them.
  localparam logic [CMD_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [CMD_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [CMD_W-1:0] ALU_AND  = 3'd2;
  localparam logic [CMD_W-1:0] ALU_OR   = 3'd3;
  localparam logic [CMD_W-1:0] ALU_XOR  = 3'd4;
  localparam logic [CMD_W-1:0] ALU_SLL  = 3'd5;
  localparam logic [CMD_W-1:0] ALU_SRL  = 3'd6;
  localparam logic [CMD_W-1:0] ALU_PASS = 3'd7;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
// Built the same with or without ALU_SCHED_PERF_EN.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (en && req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters.
// Define ALU_SCHED_PERF_EN to add the perf_ops / perf_stall counters.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      alu_valid,
  output logic [CMD_W-1:0]          alu_command,
  output logic [DATA_W-1:0]         alu_in_a,
  output logic [DATA_W-1:0]         alu_in_b,
  input  logic [DATA_W-1:0]         alu_result
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_stall
`endif
);

  alu_sched_state_e state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              take;

  logic [CMD_W-1:0]  sel_cmd_p0;
  logic [DATA_W-1:0] sel_a_p0;
  logic [DATA_W-1:0] sel_b_p0;

  logic [CMD_W-1:0]  op_cmd_p1;
  logic [DATA_W-1:0] op_a_p1;
  logic [DATA_W-1:0] op_b_p1;
  logic [ID_W-1:0]   op_id_p1;

  // Reset masks every strobe so nothing is offered or accepted while it is held.
  assign grant_en = !reset && ((state == IDLE) || (state == RESP && rsp_ready));
  assign take     = |gnt;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (grant_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_comb begin
    sel_cmd_p0 = '0;
    sel_a_p0   = '0;
    sel_b_p0   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_cmd_p0 = req_cmd[CMD_W*i +: CMD_W];
        sel_a_p0   = req_a[DATA_W*i +: DATA_W];
        sel_b_p0   = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = take ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (take)
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Stage p0 -> p1: granted operation captured for the EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_cmd_p1 <= '0;
      op_a_p1   <= '0;
      op_b_p1   <= '0;
      op_id_p1  <= '0;
    end else if (take) begin
      op_cmd_p1 <= sel_cmd_p0;
      op_a_p1   <= sel_a_p0;
      op_b_p1   <= sel_b_p0;
      op_id_p1  <= gnt_idx;
    end
  end

  assign req_ready   = gnt;
  assign alu_valid   = !reset && (state == EXEC);
  assign alu_command = op_cmd_p1;
  assign alu_in_a    = op_a_p1;
  assign alu_in_b    = op_b_p1;
  assign rsp_valid   = !reset && (state == RESP);
  assign rsp_data    = alu_result;
  assign rsp_id      = op_id_p1;

`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready)
        perf_ops <= perf_ops + 32'd1;
      if (rsp_valid && !rsp_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
